// File: rtl/bp_cce_mem_arbiter.sv
// Round-robin arbiter from several CCEs onto one memory command port, with responses steered back in order via a tag FIFO.
// Optional: define BP_CCE_MEM_ARB_STALL_CNT_EN to add the 16-bit stall_cnt_o counter.
module bp_cce_mem_arbiter #(
  parameter int num_cce_p         = 4,
  parameter int cmd_width_p       = 32,
  parameter int resp_width_p      = 32,
  parameter int max_outstanding_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_cce_p*cmd_width_p-1:0] cce_cmd_i,
  input  logic [num_cce_p-1:0]             cce_cmd_v_i,
  output logic [num_cce_p-1:0]             cce_cmd_yumi_o,
  output logic [cmd_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,
  input  logic [resp_width_p-1:0]          mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_ready_o,
  output logic [resp_width_p-1:0]          cce_resp_o,
  output logic [num_cce_p-1:0]             cce_resp_v_o,
  input  logic [num_cce_p-1:0]             cce_resp_ready_i
`ifdef BP_CCE_MEM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                      stall_cnt_o
`endif
);

  localparam int lg_cce_lp = $clog2(num_cce_p);
  localparam int ptr_w_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w_lp  = $clog2(max_outstanding_p + 1);

  logic [lg_cce_lp-1:0] rr_q, rr_d;
  logic [lg_cce_lp-1:0] tag_mem_q [max_outstanding_p];
  logic [ptr_w_lp-1:0]  rd_ptr_q, wr_ptr_q;
  logic [cnt_w_lp-1:0]  count_q;

  logic [lg_cce_lp-1:0] winner;
  logic [lg_cce_lp-1:0] head;
  logic                 any_v, tag_full, tag_empty, grant, pop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign any_v     = |cce_cmd_v_i;
  assign tag_full  = (count_q == cnt_w_lp'(max_outstanding_p));
  assign tag_empty = (count_q == '0);
  assign head      = tag_mem_q[rd_ptr_q];

  // Search upward from rr_q with wrap; first valid requester wins.
  always_comb begin
    int idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < num_cce_p; k++) begin
      idx = (int'(rr_q) + k) % num_cce_p;
      if (!found && cce_cmd_v_i[idx]) begin
        found  = 1'b1;
        winner = lg_cce_lp'(idx);
      end
    end
  end

  assign rr_d = (winner == lg_cce_lp'(num_cce_p - 1)) ? '0 : winner + 1'b1;

  assign mem_cmd_o        = cce_cmd_i[winner*cmd_width_p +: cmd_width_p];
  assign mem_cmd_v_o      = ~reset_i & any_v & ~tag_full;
  assign grant            = mem_cmd_v_o & mem_cmd_ready_i;
  assign cce_resp_o       = mem_resp_i;
  assign mem_resp_ready_o = ~reset_i & ~tag_empty & cce_resp_ready_i[head];
  assign pop              = mem_resp_v_i & mem_resp_ready_o;

  always_comb begin
    cce_cmd_yumi_o = '0;
    cce_resp_v_o   = '0;
    if (grant)
      cce_cmd_yumi_o[winner] = 1'b1;
    if (~reset_i & mem_resp_v_i & ~tag_empty)
      cce_resp_v_o[head] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (grant) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        rr_q     <= rr_d;
      end
      if (pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({grant, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage needs no reset; entries are only read while count_q says they are live.
  always_ff @(posedge clk_i) begin
    if (grant)
      tag_mem_q[wr_ptr_q] <= winner;
  end

`ifdef BP_CCE_MEM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      stall_cnt_q <= '0;
    else if (any_v && !grant && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && mem_resp_v_i && tag_empty)
      $error("bp_cce_mem_arbiter: memory response arrived with no outstanding tag");
  end
`endif

endmodule

// File: tb/tb_bp_cce_mem_arbiter.sv
// Bench for bp_cce_mem_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_bp_cce_mem_arbiter;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam int RW = 16;
  localparam int D  = 4;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N*CW-1:0] cce_cmd_i;
  logic [N-1:0]    cce_cmd_v_i;
  logic [N-1:0]    cce_cmd_yumi_o;
  logic [CW-1:0]   mem_cmd_o;
  logic            mem_cmd_v_o;
  logic            mem_cmd_ready_i;
  logic [RW-1:0]   mem_resp_i;
  logic            mem_resp_v_i;
  logic            mem_resp_ready_o;
  logic [RW-1:0]   cce_resp_o;
  logic [N-1:0]    cce_resp_v_o;
  logic [N-1:0]    cce_resp_ready_i;
`ifdef BP_CCE_MEM_ARB_STALL_CNT_EN
  logic [15:0]     stall_cnt_o;
`endif

  bp_cce_mem_arbiter #(
    .num_cce_p(N), .cmd_width_p(CW), .resp_width_p(RW), .max_outstanding_p(D)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cce_cmd_i(cce_cmd_i), .cce_cmd_v_i(cce_cmd_v_i), .cce_cmd_yumi_o(cce_cmd_yumi_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
    .cce_resp_o(cce_resp_o), .cce_resp_v_o(cce_resp_v_o), .cce_resp_ready_i(cce_resp_ready_i)
`ifdef BP_CCE_MEM_ARB_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: outstanding requesters in grant order, plus the round-robin start point.
  int rr_m;
  int q_m[$];
  int stall_m;
  int win_m;
  logic          exp_cmd_v;
  logic [N-1:0]  exp_yumi;
  logic [CW-1:0] exp_cmd;
  logic [N-1:0]  exp_resp_v;
  logic          exp_resp_rdy;

  function automatic void model_eval();
    win_m = -1;
    exp_cmd_v = 1'b0; exp_yumi = '0; exp_cmd = '0; exp_resp_v = '0; exp_resp_rdy = 1'b0;
    if (reset_i) return;
    for (int k = 0; k < N; k++)
      if (win_m < 0 && cce_cmd_v_i[(rr_m + k) % N]) win_m = (rr_m + k) % N;
    if (win_m >= 0) begin
      exp_cmd   = cce_cmd_i[win_m*CW +: CW];
      exp_cmd_v = (q_m.size() < D);
      if (exp_cmd_v && mem_cmd_ready_i) exp_yumi = N'(1 << win_m);
    end
    if (q_m.size() > 0) begin
      exp_resp_rdy = cce_resp_ready_i[q_m[0]];
      if (mem_resp_v_i) exp_resp_v = N'(1 << q_m[0]);
    end
  endfunction

  function automatic void model_update();
    logic popped, granted;
    if (reset_i) begin
      q_m.delete(); rr_m = 0; stall_m = 0;
      return;
    end
    model_eval();
    popped  = mem_resp_v_i && exp_resp_rdy;
    granted = (exp_yumi != '0);
    if ((cce_cmd_v_i != '0) && !granted && stall_m < 65535) stall_m++;
    if (popped) void'(q_m.pop_front());
    if (granted) begin
      q_m.push_back(win_m);
      rr_m = (win_m + 1) % N;
    end
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic rdy, input logic rv, input logic [N-1:0] rrdy);
    cce_cmd_v_i = v; mem_cmd_ready_i = rdy; mem_resp_v_i = rv; cce_resp_ready_i = rrdy;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    drive('0, 1'b0, 1'b0, '0);
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    cce_cmd_i = 64'h4444_3333_2222_1111;
    drive(4'hF, 1'b1, 1'b1, 4'hF);
    n_vec++; if (mem_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL rst_cmd_v got %b want 0", mem_cmd_v_o); end
    n_vec++; if (cce_cmd_yumi_o !== 4'b0) begin n_err++; $display("FAIL rst_yumi got %b want 0000", cce_cmd_yumi_o); end
    n_vec++; if (cce_resp_v_o !== 4'b0) begin n_err++; $display("FAIL rst_resp_v got %b want 0000", cce_resp_v_o); end
    n_vec++; if (mem_resp_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_resp_rdy got %b want 0", mem_resp_ready_o); end
    tick();
    mem_resp_v_i = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cce_cmd_i = {$urandom, $urandom};
      drive(4'hF, 1'b1, i > 0, 4'hF);
      n_vec++;
      if (cce_cmd_yumi_o !== 4'(1 << (i % 4))) begin
        n_err++; $display("FAIL fair_yumi cyc%0d got %b want %b", i, cce_cmd_yumi_o, 4'(1 << (i % 4)));
      end
      n_vec++;
      if (mem_cmd_o !== cce_cmd_i[(i % 4)*CW +: CW]) begin
        n_err++; $display("FAIL fair_cmd cyc%0d got %h want %h", i, mem_cmd_o, cce_cmd_i[(i % 4)*CW +: CW]);
      end
      tick();
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4'hF, 1'b1, 1'b0, 4'hF);
      n_vec++; if (cce_cmd_yumi_o !== 4'(1 << i)) begin n_err++; $display("FAIL full_fill cyc%0d got %b want %b", i, cce_cmd_yumi_o, 4'(1 << i)); end
      tick();
    end
    drive(4'hF, 1'b1, 1'b0, 4'hF);
    n_vec++; if (mem_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL full_block got %b want 0", mem_cmd_v_o); end
    tick();
    drive(4'hF, 1'b1, 1'b1, 4'hF);
    n_vec++; if (mem_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL full_pop_same got %b want 0", mem_cmd_v_o); end
    n_vec++; if (mem_resp_ready_o !== 1'b1) begin n_err++; $display("FAIL full_resp_rdy got %b want 1", mem_resp_ready_o); end
    tick();
    drive(4'hF, 1'b1, 1'b0, 4'hF);
    n_vec++; if (cce_cmd_yumi_o !== 4'b0001) begin n_err++; $display("FAIL full_resume got %b want 0001", cce_cmd_yumi_o); end
    tick();
  endtask

  task automatic test_routing();
    do_reset();
    drive(4'b0100, 1'b1, 1'b0, 4'hF);
    n_vec++; if (cce_cmd_yumi_o !== 4'b0100) begin n_err++; $display("FAIL route_g2 got %b want 0100", cce_cmd_yumi_o); end
    tick();
    drive(4'b0001, 1'b1, 1'b0, 4'hF);
    n_vec++; if (cce_cmd_yumi_o !== 4'b0001) begin n_err++; $display("FAIL route_g0 got %b want 0001", cce_cmd_yumi_o); end
    tick();
    mem_resp_i = 16'hA5C3;
    drive('0, 1'b1, 1'b1, 4'hF);
    n_vec++; if (cce_resp_v_o !== 4'b0100) begin n_err++; $display("FAIL route_r2 got %b want 0100", cce_resp_v_o); end
    n_vec++; if (cce_resp_o !== 16'hA5C3) begin n_err++; $display("FAIL route_data got %h want a5c3", cce_resp_o); end
    tick();
    drive('0, 1'b1, 1'b1, 4'hF);
    n_vec++; if (cce_resp_v_o !== 4'b0001) begin n_err++; $display("FAIL route_r0 got %b want 0001", cce_resp_v_o); end
    tick();
    drive('0, 1'b1, 1'b0, 4'hF);
    n_vec++; if (mem_resp_ready_o !== 1'b0) begin n_err++; $display("FAIL route_empty got %b want 0", mem_resp_ready_o); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(4'b0010, 1'b1, 1'b0, 4'hF);
    n_vec++; if (cce_cmd_yumi_o !== 4'b0010) begin n_err++; $display("FAIL bp_grant got %b want 0010", cce_cmd_yumi_o); end
    tick();
    mem_resp_i = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      drive('0, 1'b1, 1'b1, 4'b1101);
      n_vec++; if (mem_resp_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_hold_rdy cyc%0d got %b want 0", i, mem_resp_ready_o); end
      n_vec++; if (cce_resp_v_o !== 4'b0010) begin n_err++; $display("FAIL bp_hold_v cyc%0d got %b want 0010", i, cce_resp_v_o); end
      n_vec++; if (cce_resp_o !== 16'h1234) begin n_err++; $display("FAIL bp_hold_data cyc%0d got %h want 1234", i, cce_resp_o); end
      tick();
    end
    drive('0, 1'b1, 1'b1, 4'hF);
    n_vec++; if (mem_resp_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_accept got %b want 1", mem_resp_ready_o); end
    tick();
    drive('0, 1'b1, 1'b0, 4'hF);
    n_vec++; if (mem_resp_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b want 0", mem_resp_ready_o); end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(4'b0001, 1'b1, 1'b0, 4'hF); tick();
    drive(4'b0010, 1'b1, 1'b0, 4'hF); tick();
    drive(4'b1000, 1'b1, 1'b1, 4'hF);
    n_vec++; if (cce_cmd_yumi_o !== 4'b1000) begin n_err++; $display("FAIL sim_push got %b want 1000", cce_cmd_yumi_o); end
    n_vec++; if (cce_resp_v_o !== 4'b0001) begin n_err++; $display("FAIL sim_pop got %b want 0001", cce_resp_v_o); end
    n_vec++; if (mem_resp_ready_o !== 1'b1) begin n_err++; $display("FAIL sim_pop_rdy got %b want 1", mem_resp_ready_o); end
    tick();
    drive('0, 1'b1, 1'b1, 4'hF);
    n_vec++; if (cce_resp_v_o !== 4'b0010) begin n_err++; $display("FAIL sim_order1 got %b want 0010", cce_resp_v_o); end
    tick();
    drive('0, 1'b1, 1'b1, 4'hF);
    n_vec++; if (cce_resp_v_o !== 4'b1000) begin n_err++; $display("FAIL sim_order2 got %b want 1000", cce_resp_v_o); end
    tick();
    drive('0, 1'b1, 1'b0, 4'hF);
    n_vec++; if (mem_resp_ready_o !== 1'b0) begin n_err++; $display("FAIL sim_count got %b want 0", mem_resp_ready_o); end
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'hF, 1'b1, 1'b0, 4'hF); tick();
    end
    reset_i = 1'b1;
    drive(4'hF, 1'b1, 1'b1, 4'hF);
    n_vec++; if (cce_resp_v_o !== 4'b0) begin n_err++; $display("FAIL mrst_resp_v got %b want 0000", cce_resp_v_o); end
    n_vec++; if (cce_cmd_yumi_o !== 4'b0) begin n_err++; $display("FAIL mrst_yumi got %b want 0000", cce_cmd_yumi_o); end
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'b1010, 1'b1, 1'b0, 4'hF);
      if (i == 0) begin
        n_vec++; if (mem_resp_ready_o !== 1'b0) begin n_err++; $display("FAIL mrst_empty got %b want 0", mem_resp_ready_o); end
      end
      if (i < 4) begin
        n_vec++;
        if (cce_cmd_yumi_o !== ((i % 2 == 0) ? 4'b0010 : 4'b1000)) begin
          n_err++; $display("FAIL mrst_grant cyc%0d got %b want %b", i, cce_cmd_yumi_o, (i % 2 == 0) ? 4'b0010 : 4'b1000);
        end
      end else begin
        n_vec++; if (mem_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL mrst_full got %b want 0", mem_cmd_v_o); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic rv;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset_i    = ($urandom_range(0, 79) == 0);
      cce_cmd_i  = {$urandom, $urandom};
      mem_resp_i = RW'($urandom);
      rv = (q_m.size() > 0) ? 1'($urandom) : 1'b0;
      drive(N'($urandom), 1'($urandom_range(0, 3) != 0), rv, N'($urandom));
      n_vec++; if (mem_cmd_v_o !== exp_cmd_v) begin n_err++; $display("FAIL rnd_cmd_v cyc%0d got %b want %b", i, mem_cmd_v_o, exp_cmd_v); end
      n_vec++; if (cce_cmd_yumi_o !== exp_yumi) begin n_err++; $display("FAIL rnd_yumi cyc%0d got %b want %b", i, cce_cmd_yumi_o, exp_yumi); end
      if (exp_cmd_v) begin
        n_vec++; if (mem_cmd_o !== exp_cmd) begin n_err++; $display("FAIL rnd_cmd cyc%0d got %h want %h", i, mem_cmd_o, exp_cmd); end
      end
      n_vec++; if (cce_resp_v_o !== exp_resp_v) begin n_err++; $display("FAIL rnd_resp_v cyc%0d got %b want %b", i, cce_resp_v_o, exp_resp_v); end
      n_vec++; if (mem_resp_ready_o !== exp_resp_rdy) begin n_err++; $display("FAIL rnd_resp_rdy cyc%0d got %b want %b", i, mem_resp_ready_o, exp_resp_rdy); end
      n_vec++; if (cce_resp_o !== mem_resp_i) begin n_err++; $display("FAIL rnd_resp_data cyc%0d got %h want %h", i, cce_resp_o, mem_resp_i); end
`ifdef BP_CCE_MEM_ARB_STALL_CNT_EN
      n_vec++; if (stall_cnt_o !== 16'(stall_m)) begin n_err++; $display("FAIL rnd_stall cyc%0d got %0d want %0d", i, stall_cnt_o, stall_m); end
`endif
      tick();
    end
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    cce_cmd_i = '0; cce_cmd_v_i = '0; mem_cmd_ready_i = 1'b0;
    mem_resp_i = '0; mem_resp_v_i = 1'b0; cce_resp_ready_i = '0;
    rr_m = 0; stall_m = 0; win_m = -1;
    @(negedge clk);
    test_reset();
    test_fairness();
    test_full();
    test_routing();
    test_backpressure();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_cce_mem_arbiter.md
BP_CCE_MEM_ARBITER -- requirements
Module: bp_cce_mem_arbiter

Interface
REQ-001 SHALL have parameter num_cce_p, default "inv": number of requesting CCEs, 2..8.
REQ-002 SHALL have parameter cmd_width_p, default "inv": width of one CCE-to-mem command.
REQ-003 SHALL have parameter resp_width_p, default "inv": width of one mem-to-CCE response.
REQ-004 SHALL have parameter max_outstanding_p, default 4: depth of the in-order tag FIFO, power of 2.
REQ-005 SHALL have ports clk_i input 1 (clock) and reset_i input 1 (one clock; reset is synchronous and active-high).
REQ-006 SHALL have ports cce_cmd_i input num_cce_p*cmd_width_p; cce_cmd_v_i input num_cce_p; cce_cmd_yumi_o output num_cce_p (valid->yumi per CCE; slice i belongs to CCE i).
REQ-007 SHALL have ports mem_cmd_o output cmd_width_p; mem_cmd_v_o output 1; mem_cmd_ready_i input 1 (ready->valid to memory).
REQ-008 SHALL have ports mem_resp_i input resp_width_p; mem_resp_v_i input 1; mem_resp_ready_o output 1.
REQ-009 SHALL have ports cce_resp_o output resp_width_p (shared to all CCEs); cce_resp_v_o output num_cce_p; cce_resp_ready_i input num_cce_p.

Function
REQ-010 SHALL keep a round-robin pointer rr_r (log2 num_cce_p bits); winner = first i with cce_cmd_v_i[i] set, searching from rr_r upward with wrap-around.
REQ-011 SHALL drive mem_cmd_v_o = (any cce_cmd_v_i) & ~tag_full, with mem_cmd_o = the winner's slice, combinationally (zero-cycle latency).
REQ-012 SHALL assert cce_cmd_yumi_o[winner] only when mem_cmd_v_o & mem_cmd_ready_i; at most one yumi bit is high per cycle.
REQ-013 SHALL, on each grant, push the winner id into the tag FIFO and set rr_r to winner+1 mod num_cce_p; rr_r is unchanged on cycles without a grant.
REQ-014 SHALL hold mem_cmd_v_o low while the tag FIFO holds max_outstanding_p entries, even if a pop occurs in the same cycle.
REQ-015 SHALL route responses in order: head = tag FIFO head id; cce_resp_o = mem_resp_i; cce_resp_v_o[head] = mem_resp_v_i & ~tag_empty; all other bits 0.
REQ-016 SHALL drive mem_resp_ready_o = ~tag_empty & cce_resp_ready_i[head]; it pops the tag FIFO when mem_resp_v_i & mem_resp_ready_o.
REQ-017 SHALL support a push and a pop in the same cycle when the FIFO is neither full nor empty; the count is unchanged and both pointers advance with wrap.
REQ-018 SHALL hold mem_resp_ready_o and all cce_resp_v_o at 0 while the tag FIFO is empty; an arriving response stays pending at memory.
REQ-019 SHALL, in simulation, report an error when mem_resp_v_i is high while the tag FIFO is empty.

Reset
REQ-020 SHALL, while reset_i is high, clear rr_r, the FIFO read and write pointers and the count, and force cce_cmd_yumi_o, mem_cmd_v_o, mem_resp_ready_o and cce_resp_v_o to 0.
REQ-021 SHALL discard all outstanding tags on reset mid-operation; responses to those tags are not routed after reset.

Configuration
REQ-022 SHALL, with macro BP_CCE_MEM_ARB_STALL_CNT_EN defined, add output stall_cnt_o (16 bits) with the following behaviour:
- increments on each cycle where any cce_cmd_v_i is set and no yumi is issued;
- saturates at 0xFFFF;
- cleared by reset.
REQ-023 SHALL, without BP_CCE_MEM_ARB_STALL_CNT_EN, omit stall_cnt_o and the counter logic, with all other behaviour identical.

Verification
REQ-024 Fairness: num_cce_p=4, all valid, mem_cmd_ready_i=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3.
REQ-025 Full: max_outstanding_p=4, 4 grants with no responses -> mem_cmd_v_o=0 on the 5th cycle; one response -> grant resumes the next cycle.
REQ-026 Routing: grant CCE2 then CCE0; two responses -> cce_resp_v_o=4'b0100, then 4'b0001.
REQ-027 Backpressure: response for CCE1 with cce_resp_ready_i[1]=0 for 3 cycles -> mem_resp_ready_o=0 for those 3 cycles, no pop, resp held; accepted on the 4th cycle.
REQ-028 Simultaneous: count=2, push and pop in the same cycle -> count remains 2 and order is preserved.
REQ-029 Reset: reset_i after 3 grants -> count=0, rr_r=0; the first grant after reset goes to the lowest valid index.
